// File: rtl/log2_pkg.sv
// Shared constants and sizing helper for the log2 block.
package log2_pkg;

   localparam int unsigned SIZE_IN_DEF = 16;

   // Index width for an n-bit word, never narrower than one bit.
   function automatic int unsigned clog2_safe(input int unsigned n);
      int unsigned c;
      c = $clog2(n);
      return (c < 1) ? 1 : c;
   endfunction

endpackage

// File: rtl/log2_prio_enc.sv
// Combinational MSB priority encoder built as a log-depth OR-reduce tree.
module log2_prio_enc
   import log2_pkg::*;
#(
   parameter int unsigned SIZE_IN  = SIZE_IN_DEF,
   parameter int unsigned SIZE_OUT = clog2_safe(SIZE_IN)
) (
   input  logic [SIZE_IN-1:0]  num,
   output logic [SIZE_OUT-1:0] idx,
   output logic                any
);

   localparam int unsigned LVLS = clog2_safe(SIZE_IN);
   localparam int unsigned PW   = 1 << LVLS;

   logic [PW-1:0]   vec;
   logic [LVLS-1:0] raw;

   // Per level: if the upper half of the window has a set bit, take it and shift it down.
   always_comb begin
      vec = PW'(num);
      raw = '0;
      for (int lvl = int'(LVLS) - 1; lvl >= 0; lvl--) begin
         if ((vec >> (1 << lvl)) != '0) begin
            raw[lvl] = 1'b1;
            vec      = vec >> (1 << lvl);
         end
      end
   end

   // Upper index bits stay zero when SIZE_OUT is wider than needed.
   always_comb begin
      idx = SIZE_OUT'(raw);
      any = |num;
   end

endmodule

// File: rtl/log2.sv
// Registered floor(log2(num)) with a zero-input flag; one cycle of latency.
module log2
   import log2_pkg::*;
#(
   parameter int unsigned SIZE_IN  = SIZE_IN_DEF,
   parameter int unsigned SIZE_OUT = clog2_safe(SIZE_IN)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SIZE_IN-1:0]  num,
   output logic [SIZE_OUT-1:0] degree,
   output logic                zero
);

   logic [SIZE_OUT-1:0] enc_idx;
   logic                enc_any;

   log2_prio_enc #(
      .SIZE_IN  (SIZE_IN),
      .SIZE_OUT (SIZE_OUT)
   ) u_enc (
      .num (num),
      .idx (enc_idx),
      .any (enc_any)
   );

   // Output register; reset wins over the sampled operand.
   always_ff @(posedge clk) begin
      if (rst) begin
         degree <= '0;
         zero   <= 1'b1;
      end else begin
         degree <= enc_idx;
         zero   <= ~enc_any;
      end
   end

endmodule

// File: tb/tb_log2.sv
// Scoreboard bench for log2 at SIZE_IN = 16, 8 and 12.
module tb_log2;
   import log2_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] num16 = '0;
   logic [7:0]  num8  = '0;
   logic [11:0] num12 = '0;
   logic [3:0]  degree16;
   logic [2:0]  degree8;
   logic [3:0]  degree12;
   logic        zero16, zero8, zero12;

   int n_tests = 0;
   int n_fail  = 0;
   int q16[$];
   int q8[$];
   int q12[$];

   always #5 clk = ~clk;

   log2 #(.SIZE_IN(16)) dut16 (.clk(clk), .rst(rst), .num(num16), .degree(degree16), .zero(zero16));
   log2 #(.SIZE_IN(8))  dut8  (.clk(clk), .rst(rst), .num(num8),  .degree(degree8),  .zero(zero8));
   log2 #(.SIZE_IN(12)) dut12 (.clk(clk), .rst(rst), .num(num12), .degree(degree12), .zero(zero12));

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got zero/deg=0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Behavioural reference: last set bit wins; result packed as {zero, degree}.
   function automatic int ref_model(input logic [31:0] v, input int w, input logic r);
      int d;
      d = 0;
      if (r) return 32'h100;
      for (int i = 0; i < w; i++) if (v[i]) d = i;
      return (v == 0) ? 32'h100 : d;
   endfunction

   function automatic int pack_out(input logic z, input logic [3:0] d);
      return (int'(z) << 8) | int'(d);
   endfunction

   // Drive one cycle on the falling edge, predict, then compare after the rising edge.
   task automatic cycle(input string tag, input logic r, input logic [15:0] a,
                        input logic [7:0] b, input logic [11:0] c);
      int e;
      @(negedge clk);
      rst = r; num16 = a; num8 = b; num12 = c;
      q16.push_back(ref_model(32'(a), 16, r));
      q8.push_back(ref_model(32'(b), 8, r));
      q12.push_back(ref_model(32'(c), 12, r));
      @(posedge clk);
      #1;
      e = q16.pop_front(); chk({tag, "/16"}, pack_out(zero16, degree16), e);
      e = q8.pop_front();  chk({tag, "/8"},  pack_out(zero8, {1'b0, degree8}), e);
      e = q12.pop_front(); chk({tag, "/12"}, pack_out(zero12, degree12), e);
   endtask

   initial begin
      logic [15:0] nonpow [5];
      int          nonexp [5];
      int          held;
      logic [31:0] rv;
      nonpow = '{16'h0003, 16'h0005, 16'h00FF, 16'h8001, 16'hFFFF};
      nonexp = '{1, 2, 7, 15, 15};

      // Reset held with all-ones input.
      for (int i = 0; i < 3; i++) cycle("reset", 1'b1, 16'hFFFF, 8'hFF, 12'hFFF);
      chk("reset_const", pack_out(zero16, degree16), 32'h100);
      cycle("release", 1'b0, 16'hFFFF, 8'hFF, 12'hFFF);
      chk("release_const", pack_out(zero16, degree16), 15);

      // Powers of two.
      for (int k = 0; k < 16; k++)
         cycle("pow2", 1'b0, 16'(1 << k), 8'(1 << (k % 8)), 12'(1 << (k % 12)));

      // Non-powers, with fixed expectations on the 16-bit instance.
      for (int i = 0; i < 5; i++) begin
         cycle("nonpow", 1'b0, nonpow[i], nonpow[i][7:0], nonpow[i][11:0]);
         chk("nonpow_const", pack_out(zero16, degree16), nonexp[i]);
      end

      // Zero after 0x0100, then 1.
      cycle("pre_zero", 1'b0, 16'h0100, 8'h00, 12'h100);
      cycle("zero", 1'b0, 16'h0000, 8'h00, 12'h000);
      chk("zero_const", pack_out(zero16, degree16), 32'h100);
      cycle("one", 1'b0, 16'h0001, 8'h01, 12'h001);
      chk("one_const", pack_out(zero16, degree16), 0);

      // Alternate widths at their boundaries.
      cycle("alt", 1'b0, 16'h4000, 8'h80, 12'h800);
      chk("sz8_0x80", pack_out(zero8, {1'b0, degree8}), 7);
      chk("sz12_0x800", pack_out(zero12, degree12), 11);
      cycle("alt", 1'b0, 16'h2000, 8'h7F, 12'h7FF);
      chk("sz12_0x7ff", pack_out(zero12, degree12), 10);
      chk("sz8_0x7f", pack_out(zero8, {1'b0, degree8}), 6);

      // Output must not follow num before the next edge.
      held = pack_out(zero16, degree16);
      @(negedge clk);
      num16 = 16'h0001;
      #2;
      chk("no_comb_path", pack_out(zero16, degree16), 13);
      if (held != 13) chk("held_prev", held, 13);

      // Random stream with a one-cycle mid-stream reset.
      for (int i = 0; i < 60; i++) begin
         rv = $urandom;
         rv = rv >> $urandom_range(0, 16);
         cycle("rand", (i == 30) ? 1'b1 : 1'b0, rv[15:0], rv[7:0], rv[11:0]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
